// File: rtl/spi_pkg.sv
// Shared definitions for the SPI slave endpoint.
//   DataWidth : default frame length in bits
//   CntWidth  : bit-counter width for the default frame length
//   cnt_width : counter width for an arbitrary frame length (at least 1 bit)
package spi_pkg;

  localparam int unsigned DataWidth = 8;
  localparam int unsigned CntWidth  = $clog2(DataWidth);

  function automatic int unsigned cnt_width(input int unsigned width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/spi_shift_unit.sv
// Right-shifting register with a modulo-Width bit counter. It serves as both the
// transmit path (clocked on rising SCLK) and the receive path (clocked on inverted SCLK).
//   clk_i       : shift clock
//   rst_i       : synchronous active-high reset; clears the register and the counter
//   clr_i       : clears only the counter (chip select inactive)
//   en_i        : advance one bit
//   load_i      : take load_data_i instead of the register as the source of this step
//   load_data_i : parallel word used when load_i is set
//   shift_in_i  : bit entering at the MSB
//   bit0_o      : LSB of the source word for this step (the bit shifted out)
//   next_o      : register value after this step
//   first_o     : counter is at 0 (first bit of a frame)
//   last_o      : counter is at Width-1 (last bit of a frame)
// Width must be at least 2.
module spi_shift_unit #(
  parameter int unsigned Width = 8,
  parameter int unsigned CntW  = 3
) (
  input  logic             clk_i,
  input  logic             rst_i,
  input  logic             clr_i,
  input  logic             en_i,
  input  logic             load_i,
  input  logic [Width-1:0] load_data_i,
  input  logic             shift_in_i,
  output logic             bit0_o,
  output logic [Width-1:0] next_o,
  output logic             first_o,
  output logic             last_o
);

  logic [Width-1:0] shift_q, shift_d, src;
  logic [CntW-1:0]  cnt_q, cnt_d;

  always_comb begin
    src     = load_i ? load_data_i : shift_q;
    shift_d = {shift_in_i, src[Width-1:1]};
    first_o = (cnt_q == '0);
    last_o  = (cnt_q == CntW'(Width - 1));
    cnt_d   = last_o ? '0 : cnt_q + 1'b1;
    bit0_o  = src[0];
    next_o  = shift_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      shift_q <= '0;
      cnt_q   <= '0;
    end else if (clr_i) begin
      cnt_q   <= '0;
    end else if (en_i) begin
      shift_q <= shift_d;
      cnt_q   <= cnt_d;
    end
  end

endmodule

// File: rtl/spi_slave.sv
// SPI slave endpoint: one full-duplex, LSB-first frame per DATA_WIDTH bits while CS is low.
// MISO is launched on rising SCLK and MOSI is sampled on falling SCLK.
//   SCLK              : serial clock, the only clock (both edges used)
//   reset             : synchronous active-high reset, checked on both SCLK edges
//   slaveDataToSend   : word to transmit, captured on the first rising edge of a frame
//   slaveDataReceived : last complete word received
//   CS                : chip select, active low; high aborts any partial frame
//   MOSI              : master-out serial data
//   MISO              : slave-out serial data, high-Z while CS is high
module spi_slave
  import spi_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DataWidth
) (
  input  logic                  SCLK,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] slaveDataToSend,
  output logic [DATA_WIDTH-1:0] slaveDataReceived,
  input  logic                  CS,
  input  logic                  MOSI,
  output logic                  MISO
);

  localparam int unsigned CntW = cnt_width(DATA_WIDTH);

  logic                  sclk_n;
  logic                  tx_bit, tx_first;
  logic                  rx_last;
  logic [DATA_WIDTH-1:0] rx_word;
  logic                  miso_q;
  logic [DATA_WIDTH-1:0] rx_data_q;

  // Outputs of the shared shift unit that one direction does not need.
  logic [DATA_WIDTH-1:0] unused_tx_next;
  logic                  unused_tx_last, unused_rx_bit0, unused_rx_first;
  logic                  unused_sig;

  // Receive domain runs on falling SCLK.
  assign sclk_n = ~SCLK;

  // Transmit path: reload the word whenever the counter is back at 0, so
  // back-to-back frames pick up a fresh slaveDataToSend without a CS toggle.
  spi_shift_unit #(
    .Width (DATA_WIDTH),
    .CntW  (CntW)
  ) u_tx (
    .clk_i       (SCLK),
    .rst_i       (reset),
    .clr_i       (CS),
    .en_i        (~CS),
    .load_i      (tx_first),
    .load_data_i (slaveDataToSend),
    .shift_in_i  (1'b0),
    .bit0_o      (tx_bit),
    .next_o      (unused_tx_next),
    .first_o     (tx_first),
    .last_o      (unused_tx_last)
  );

  spi_shift_unit #(
    .Width (DATA_WIDTH),
    .CntW  (CntW)
  ) u_rx (
    .clk_i       (sclk_n),
    .rst_i       (reset),
    .clr_i       (CS),
    .en_i        (~CS),
    .load_i      (1'b0),
    .load_data_i ('0),
    .shift_in_i  (MOSI),
    .bit0_o      (unused_rx_bit0),
    .next_o      (rx_word),
    .first_o     (unused_rx_first),
    .last_o      (rx_last)
  );

  assign unused_sig = ^{unused_tx_next, unused_tx_last, unused_rx_bit0, unused_rx_first};

  always_ff @(posedge SCLK) begin
    if (reset) begin
      miso_q <= 1'b0;
    end else if (!CS) begin
      miso_q <= tx_bit;
    end
  end

  // The completed word is published on the same falling edge that samples its last bit.
  always_ff @(posedge sclk_n) begin
    if (reset) begin
      rx_data_q <= '0;
    end else if (!CS && rx_last) begin
      rx_data_q <= rx_word;
    end
  end

  assign slaveDataReceived = rx_data_q;
  assign MISO              = CS ? 1'bz : miso_q;

endmodule

// File: tb/tb_spi_slave.sv
module tb_spi_slave;

  logic       SCLK = 1'b0;
  logic       reset;
  logic [7:0] tx_data;
  logic [7:0] rx_data;
  logic       CS;
  logic       MOSI;
  wire        MISO;

  // A floating MISO reads as 1, a driven one shows the slave's bit.
  pullup (MISO);

  spi_slave #(
    .DATA_WIDTH (8)
  ) dut (
    .SCLK              (SCLK),
    .reset             (reset),
    .slaveDataToSend   (tx_data),
    .slaveDataReceived (rx_data),
    .CS                (CS),
    .MOSI              (MOSI),
    .MISO              (MISO)
  );

  always #5 SCLK = ~SCLK;

  int vectors     = 0;
  int miscompares = 0;

  // Reference model: last word the slave should report.
  logic [7:0] model_rx;

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    vectors++;
    assert (obs === exp)
    else begin
      miscompares++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // One master bit: drive MOSI after the rising edge, capture MISO after the falling edge.
  task automatic xfer_bit(input logic mb, output logic sb);
    @(posedge SCLK);
    #1 MOSI = mb;
    @(negedge SCLK);
    #1 sb = MISO;
  endtask

  task automatic frame(input logic [7:0] m, input int nbits, output logic [7:0] cap);
    logic b;
    cap = '0;
    for (int i = 0; i < nbits; i++) begin
      xfer_bit(m[i], b);
      cap[i] = b;
    end
  endtask

  // Raise CS for one full SCLK cycle so both edge domains see it.
  task automatic idle();
    CS = 1'b1;
    @(posedge SCLK);
    @(negedge SCLK);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, observed timeout expected finish");
    $fatal(1);
  end

  initial begin
    logic [7:0] cap, m, s;
    logic       b;
    int         nb;
    bit         chg;
    bit         aligned;

    reset   = 1'b1;
    CS      = 1'b1;
    MOSI    = 1'b0;
    tx_data = '0;
    model_rx = '0;
    repeat (2) @(negedge SCLK);
    #1;
    check("reset_rx", rx_data, 8'h00);
    check("reset_miso_z", {7'b0, MISO}, 8'h01);
    reset = 1'b0;

    // Frame 1
    tx_data = 8'b0000_1001;
    CS = 1'b0;
    frame(8'b0101_0011, 8, cap);
    model_rx = 8'b0101_0011;
    check("f1_rx", rx_data, model_rx);
    check("f1_miso", cap, 8'b0000_1001);

    // Frame 2, CS kept low
    tx_data = 8'b1001_1000;
    frame(8'b0011_1100, 8, cap);
    model_rx = 8'b0011_1100;
    check("f2_rx", rx_data, model_rx);
    check("f2_miso", cap, 8'b1001_1000);

    // Partial frame then a clean full frame
    idle();
    CS = 1'b0;
    tx_data = 8'h66;
    frame(8'hA5, 4, cap);
    idle();
    check("partial_rx_hold", rx_data, model_rx);
    CS = 1'b0;
    tx_data = 8'hC3;
    frame(8'h5A, 8, cap);
    model_rx = 8'h5A;
    check("after_partial_rx", rx_data, model_rx);
    check("after_partial_miso", cap, 8'hC3);

    // Reset mid-frame with CS low: MISO is driven 0, received word cleared
    tx_data = 8'hFF;
    frame(8'h3C, 3, cap);
    reset = 1'b1;
    @(posedge SCLK);
    #1;
    check("reset_miso_cs_low", {7'b0, MISO}, 8'h00);
    @(negedge SCLK);
    #1;
    reset = 1'b0;
    model_rx = '0;
    check("midreset_rx", rx_data, model_rx);
    tx_data = 8'h00;
    frame(8'hFF, 8, cap);
    model_rx = 8'hFF;
    check("post_reset_rx", rx_data, model_rx);
    check("post_reset_miso", cap, 8'h00);
    idle();
    check("idle_miso_z", {7'b0, MISO}, 8'h01);

    // slaveDataToSend changed after the first bit
    CS = 1'b0;
    tx_data = 8'h96;
    xfer_bit(1'b1, b);
    cap = '0;
    cap[0] = b;
    tx_data = 8'h3E;
    for (int i = 1; i < 8; i++) begin
      xfer_bit(1'b0, b);
      cap[i] = b;
    end
    model_rx = 8'h01;
    check("midchg_miso", cap, 8'h96);
    check("midchg_rx", rx_data, model_rx);
    frame(8'h24, 8, cap);
    model_rx = 8'h24;
    check("midchg_next_miso", cap, 8'h3E);
    check("midchg_next_rx", rx_data, model_rx);

    // Randomized frames: mix of full, partial, back-to-back and mid-frame changes
    aligned = 1'b1;
    for (int it = 0; it < 24; it++) begin
      m   = 8'($urandom);
      s   = 8'($urandom);
      nb  = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 7)) : 8;
      chg = 1'($urandom_range(0, 1));
      if (!aligned || $urandom_range(0, 1) == 1) begin
        idle();
        CS = 1'b0;
      end
      tx_data = s;
      cap = '0;
      for (int i = 0; i < nb; i++) begin
        xfer_bit(m[i], b);
        cap[i] = b;
        if (i == 0 && chg) tx_data = 8'($urandom);
      end
      if (nb == 8) begin
        model_rx = m;
        check("rand_miso", cap, s);
        check("rand_rx", rx_data, model_rx);
        aligned = 1'b1;
      end else begin
        idle();
        check("rand_partial_rx", rx_data, model_rx);
        aligned = 1'b0;
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
